// File: rtl/target_report_fifo.sv
// Packs swd target start/end events into 32-bit records and buffers them in a RAM FIFO.
// The host reads one record per rising edge of rden, with drop-on-full accounting.
module target_report_fifo #(
   parameter int ADDR_W     = 10,
   parameter int BEAR_W     = 12,
   parameter int DEPTH_LOG2 = 9,
   parameter int AFULL_TH   = 480
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [BEAR_W-1:0]     bear,
   input  logic                  f1,
   input  logic                  f2,
   input  logic                  nv_mti_door,
   input  logic                  swd_done,
   input  logic                  target_start,
   input  logic                  target_end,
   input  logic                  rden,
   input  logic                  clr_ovf,
   output logic [31:0]           rddata,
   output logic                  rdstb,
   output logic [3:0]            rdstate,
   output logic [DEPTH_LOG2:0]   level,
   output logic [15:0]           drop_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LVL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   AFULL_LVL = (DEPTH_LOG2+1)'(AFULL_TH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {IDLE, RD, LAT} rd_state_t;

   rd_state_t               state_reg;
   logic [31:0]             mem [DEPTH];
   logic [31:0]             ram_q_reg;
   logic [DEPTH_LOG2-1:0]   wptr_reg, rptr_reg;
   logic [DEPTH_LOG2:0]     level_reg, level_next;
   logic                    full_reg, empty_reg, afull_reg, ovf_reg, ovf_next;
   logic [15:0]             drop_cnt_reg, drop_cnt_next;
   logic                    pend_valid_reg, pend_valid_next;
   logic [31:0]             pend_data_reg, pend_data_next;
   logic                    pnew_reg, pold_reg;
   logic [31:0]             rddata_reg;
   logic                    rdstb_reg;

   logic        ev_start, ev_end, push_req, push_ok, full_drop, lost, pop, rd_edge;
   logic [31:0] body, start_rec, end_rec, push_data;
   logic [15:0] drop_base;
   logic [16:0] drop_sum;

   always_comb begin
      ev_start  = swd_done & target_start;
      ev_end    = swd_done & target_end;
      body      = 32'({f2, f1, bear, addr});
      start_rec = {2'b01, nv_mti_door, body[28:0]};
      end_rec   = {2'b10, nv_mti_door, body[28:0]};

      push_req        = 1'b0;
      push_data       = start_rec;
      pend_valid_next = 1'b0;
      pend_data_next  = pend_data_reg;
      lost            = 1'b0;
      // A held record always drains first; new events queue behind it, at most one deep.
      if (pend_valid_reg) begin
         push_req  = 1'b1;
         push_data = pend_data_reg;
         if (ev_start) begin
            pend_valid_next = 1'b1;
            pend_data_next  = start_rec;
            lost            = ev_end;
         end else if (ev_end) begin
            pend_valid_next = 1'b1;
            pend_data_next  = end_rec;
         end
      end else if (ev_start) begin
         push_req  = 1'b1;
         push_data = start_rec;
         if (ev_end) begin
            pend_valid_next = 1'b1;
            pend_data_next  = end_rec;
         end
      end else if (ev_end) begin
         push_req  = 1'b1;
         push_data = end_rec;
      end

      push_ok   = push_req & ~full_reg;
      full_drop = push_req & full_reg;
      pop       = (state_reg == LAT);
      rd_edge   = pnew_reg & ~pold_reg;

      level_next = level_reg;
      if (push_ok && !pop)
         level_next = level_reg + LVL_ONE;
      else if (!push_ok && pop)
         level_next = level_reg - LVL_ONE;

      // Clear is applied before this cycle's drops, so a coincident drop survives it.
      drop_base     = clr_ovf ? 16'h0000 : drop_cnt_reg;
      drop_sum      = {1'b0, drop_base} + 17'(full_drop) + 17'(lost);
      drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      ovf_next      = (full_drop | lost) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_reg);
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr_reg] <= push_data;
      if (state_reg == RD)
         ram_q_reg <= mem[rptr_reg];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         wptr_reg       <= '0;
         rptr_reg       <= '0;
         level_reg      <= '0;
         full_reg       <= 1'b0;
         empty_reg      <= 1'b1;
         afull_reg      <= 1'b0;
         ovf_reg        <= 1'b0;
         drop_cnt_reg   <= '0;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= '0;
         pnew_reg       <= 1'b0;
         pold_reg       <= 1'b0;
         rddata_reg     <= '0;
         rdstb_reg      <= 1'b1;
      end else begin
         pnew_reg       <= rden;
         pold_reg       <= pnew_reg;
         pend_valid_reg <= pend_valid_next;
         pend_data_reg  <= pend_data_next;
         drop_cnt_reg   <= drop_cnt_next;
         ovf_reg        <= ovf_next;
         level_reg      <= level_next;
         full_reg       <= (level_next == FULL_LVL);
         empty_reg      <= (level_next == '0);
         afull_reg      <= (level_next >= AFULL_LVL);
         if (push_ok)
            wptr_reg <= wptr_reg + PTR_ONE;
         case (state_reg)
            IDLE: if (rd_edge && !empty_reg) begin
               state_reg <= RD;
               rdstb_reg <= 1'b0;
            end
            RD:   state_reg <= LAT;
            LAT: begin
               rddata_reg <= ram_q_reg;
               rptr_reg   <= rptr_reg + PTR_ONE;
               rdstb_reg  <= 1'b1;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rddata   = rddata_reg;
   assign rdstb    = rdstb_reg;
   assign rdstate  = {ovf_reg, empty_reg, afull_reg, full_reg};
   assign level    = level_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_target_report_fifo.sv
// Directed bench for target_report_fifo: record packing, pend ordering, full/drop,
// almost-full, read-edge behaviour and reset during a read.
module tb_target_report_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  addr = '0;
   logic [11:0] bear = '0;
   logic        f1 = 1'b0, f2 = 1'b0, nv_mti_door = 1'b0;
   logic        swd_done = 1'b0, target_start = 1'b0, target_end = 1'b0;
   logic        rden = 1'b0, clr_ovf = 1'b0;
   logic [31:0] rddata;
   logic        rdstb;
   logic [3:0]  rdstate;
   logic [9:0]  level;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad = 0;

   target_report_fifo #(.ADDR_W(10), .BEAR_W(12), .DEPTH_LOG2(9), .AFULL_TH(480)) dut (
      .clk(clk), .reset(reset), .addr(addr), .bear(bear), .f1(f1), .f2(f2),
      .nv_mti_door(nv_mti_door), .swd_done(swd_done), .target_start(target_start),
      .target_end(target_end), .rden(rden), .clr_ovf(clr_ovf), .rddata(rddata),
      .rdstb(rdstb), .rdstate(rdstate), .level(level), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // All helpers start and end on a falling edge.
   task automatic apply_reset;
      swd_done = 0; target_start = 0; target_end = 0; rden = 0; clr_ovf = 0;
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
   endtask

   task automatic push_evt(input logic s, input logic e, input logic [9:0] a, input logic [11:0] b,
                           input logic ff1, input logic ff2, input logic dr);
      swd_done = 1; target_start = s; target_end = e;
      addr = a; bear = b; f1 = ff1; f2 = ff2; nv_mti_door = dr;
      @(negedge clk);
      swd_done = 0; target_start = 0; target_end = 0;
   endtask

   task automatic fill(input int n, input int base);
      for (int i = 0; i < n; i++) push_evt(1'b1, 1'b0, 10'(base + i), 12'h000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_read(output int to_low, output int low_len);
      rden = 1;
      to_low = 0;
      while (to_low < 20) begin
         @(negedge clk);
         to_low++;
         if (rdstb === 1'b0) break;
      end
      low_len = 0;
      while (rdstb === 1'b0 && low_len < 20) begin
         @(negedge clk);
         low_len++;
      end
      rden = 0;
      @(negedge clk);
      $display("read: data=%h level=%0d", rddata, level);
   endtask

   task automatic test_reset;
      apply_reset();
      total++; if (rddata !== 32'h0) begin bad++; $display("FAIL reset_rddata got=%h want=0", rddata); end
      total++; if (rdstb !== 1'b1) begin bad++; $display("FAIL reset_rdstb got=%b want=1", rdstb); end
      total++; if (level !== 10'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
      total++; if (rdstate !== 4'b0100) begin bad++; $display("FAIL reset_rdstate got=%b want=0100", rdstate); end
   endtask

   task automatic test_single;
      int tl, ll;
      push_evt(1'b1, 1'b0, 10'h155, 12'hABC, 1'b1, 1'b0, 1'b1);
      total++; if (level !== 10'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
      total++; if (rdstate !== 4'b0000) begin bad++; $display("FAIL single_state got=%b want=0000", rdstate); end
      do_read(tl, ll);
      total++; if (tl !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", tl); end
      total++; if (ll !== 2) begin bad++; $display("FAIL single_lowlen got=%0d want=2", ll); end
      total++; if (rddata !== 32'h606AF155) begin bad++; $display("FAIL single_data got=%h want=606af155", rddata); end
      total++; if (level !== 10'd0) begin bad++; $display("FAIL single_level_after got=%0d want=0", level); end
      total++; if (rdstate !== 4'b0100) begin bad++; $display("FAIL single_state_after got=%b want=0100", rdstate); end
   endtask

   task automatic test_start_end;
      int tl, ll;
      push_evt(1'b1, 1'b1, 10'h3A5, 12'h123, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (level !== 10'd2) begin bad++; $display("FAIL both_level got=%0d want=2", level); end
      do_read(tl, ll);
      total++; if (rddata !== 32'h40848FA5) begin bad++; $display("FAIL both_first got=%h want=40848fa5", rddata); end
      do_read(tl, ll);
      total++; if (rddata !== 32'h80848FA5) begin bad++; $display("FAIL both_second got=%h want=80848fa5", rddata); end
      total++; if (level !== 10'd0) begin bad++; $display("FAIL both_level_after got=%0d want=0", level); end
   endtask

   task automatic test_back_to_back;
      int tl, ll;
      push_evt(1'b1, 1'b1, 10'h00B, 12'h000, 1'b0, 1'b0, 1'b0);
      push_evt(1'b1, 1'b1, 10'h016, 12'h000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++; if (level !== 10'd3) begin bad++; $display("FAIL b2b_level got=%0d want=3", level); end
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL b2b_drop got=%0d want=1", drop_cnt); end
      total++; if (rdstate !== 4'b1000) begin bad++; $display("FAIL b2b_state got=%b want=1000", rdstate); end
      do_read(tl, ll);
      total++; if (rddata !== 32'h4000000B) begin bad++; $display("FAIL b2b_rd0 got=%h want=4000000b", rddata); end
      do_read(tl, ll);
      total++; if (rddata !== 32'h8000000B) begin bad++; $display("FAIL b2b_rd1 got=%h want=8000000b", rddata); end
      do_read(tl, ll);
      total++; if (rddata !== 32'h40000016) begin bad++; $display("FAIL b2b_rd2 got=%h want=40000016", rddata); end
      clr_ovf = 1;
      @(negedge clk);
      clr_ovf = 0;
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL b2b_clr_drop got=%0d want=0", drop_cnt); end
      total++; if (rdstate !== 4'b0100) begin bad++; $display("FAIL b2b_clr_state got=%b want=0100", rdstate); end
   endtask

   task automatic test_full;
      apply_reset();
      fill(512, 0);
      total++; if (level !== 10'd512) begin bad++; $display("FAIL full_level got=%0d want=512", level); end
      total++; if (rdstate !== 4'b0011) begin bad++; $display("FAIL full_state got=%b want=0011", rdstate); end
      fill(3, 600);
      total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL full_drop got=%0d want=3", drop_cnt); end
      total++; if (rdstate !== 4'b1011) begin bad++; $display("FAIL full_ovf_state got=%b want=1011", rdstate); end
      total++; if (level !== 10'd512) begin bad++; $display("FAIL full_level_hold got=%0d want=512", level); end
      // Push lands on the pop cycle: full on the pre-cycle level still drops it.
      rden = 1;
      repeat (3) @(negedge clk);
      push_evt(1'b1, 1'b0, 10'h3AA, 12'h000, 1'b0, 1'b0, 1'b0);
      rden = 0;
      @(negedge clk);
      total++; if (level !== 10'd511) begin bad++; $display("FAIL full_pop_level got=%0d want=511", level); end
      total++; if (drop_cnt !== 16'd4) begin bad++; $display("FAIL full_pop_drop got=%0d want=4", drop_cnt); end
      total++; if (rddata !== 32'h40000000) begin bad++; $display("FAIL full_pop_data got=%h want=40000000", rddata); end
      clr_ovf = 1;
      @(negedge clk);
      clr_ovf = 0;
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL full_clr_drop got=%0d want=0", drop_cnt); end
      total++; if (rdstate !== 4'b0010) begin bad++; $display("FAIL full_clr_state got=%b want=0010", rdstate); end
      push_evt(1'b1, 1'b0, 10'h3FF, 12'h000, 1'b0, 1'b0, 1'b0);
      clr_ovf = 1;
      push_evt(1'b1, 1'b0, 10'h3FE, 12'h000, 1'b0, 1'b0, 1'b0);
      clr_ovf = 0;
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL full_clrdrop_cnt got=%0d want=1", drop_cnt); end
      total++; if (rdstate !== 4'b1011) begin bad++; $display("FAIL full_clrdrop_state got=%b want=1011", rdstate); end
   endtask

   task automatic test_afull;
      int tl, ll;
      apply_reset();
      fill(479, 0);
      total++; if (rdstate !== 4'b0000) begin bad++; $display("FAIL afull_479_state got=%b want=0000", rdstate); end
      fill(1, 479);
      total++; if (level !== 10'd480) begin bad++; $display("FAIL afull_level got=%0d want=480", level); end
      total++; if (rdstate !== 4'b0010) begin bad++; $display("FAIL afull_state got=%b want=0010", rdstate); end
      do_read(tl, ll);
      total++; if (level !== 10'd479) begin bad++; $display("FAIL afull_rd_level got=%0d want=479", level); end
      total++; if (rdstate !== 4'b0000) begin bad++; $display("FAIL afull_rd_state got=%b want=0000", rdstate); end
      total++; if (rddata !== 32'h40000000) begin bad++; $display("FAIL afull_rd_data got=%h want=40000000", rddata); end
   endtask

   task automatic test_empty_and_hold;
      int tl, ll, lows;
      apply_reset();
      push_evt(1'b1, 1'b0, 10'h02A, 12'h005, 1'b0, 1'b1, 1'b1);
      do_read(tl, ll);
      total++; if (rddata !== 32'h6080142A) begin bad++; $display("FAIL empty_prep_data got=%h want=6080142a", rddata); end
      rden = 1;
      lows = 0;
      repeat (6) begin
         @(negedge clk);
         if (rdstb !== 1'b1) lows++;
      end
      rden = 0;
      @(negedge clk);
      total++; if (lows !== 0) begin bad++; $display("FAIL empty_rdstb_lows got=%0d want=0", lows); end
      total++; if (rddata !== 32'h6080142A) begin bad++; $display("FAIL empty_data_kept got=%h want=6080142a", rddata); end
      push_evt(1'b1, 1'b0, 10'h001, 12'h000, 1'b0, 1'b0, 1'b0);
      push_evt(1'b1, 1'b0, 10'h002, 12'h000, 1'b0, 1'b0, 1'b0);
      rden = 1;
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (rdstb === 1'b0) lows++;
      end
      rden = 0;
      @(negedge clk);
      total++; if (lows !== 2) begin bad++; $display("FAIL hold_rdstb_lows got=%0d want=2", lows); end
      total++; if (level !== 10'd1) begin bad++; $display("FAIL hold_level got=%0d want=1", level); end
      total++; if (rddata !== 32'h40000001) begin bad++; $display("FAIL hold_data got=%h want=40000001", rddata); end
   endtask

   task automatic test_reset_mid_read;
      apply_reset();
      push_evt(1'b1, 1'b0, 10'h007, 12'h000, 1'b0, 1'b0, 1'b0);
      rden = 1;
      repeat (2) @(negedge clk);
      total++; if (rdstb !== 1'b0) begin bad++; $display("FAIL midrd_busy got=%b want=0", rdstb); end
      push_evt(1'b1, 1'b1, 10'h009, 12'h000, 1'b0, 1'b0, 1'b0);
      total++; if (level !== 10'd2) begin bad++; $display("FAIL midrd_level_pre got=%0d want=2", level); end
      rden = 0;
      reset = 0;
      #1;
      total++; if (rdstb !== 1'b1) begin bad++; $display("FAIL midrd_rdstb got=%b want=1", rdstb); end
      total++; if (level !== 10'd0) begin bad++; $display("FAIL midrd_level got=%0d want=0", level); end
      total++; if (rddata !== 32'h0) begin bad++; $display("FAIL midrd_rddata got=%h want=0", rddata); end
      total++; if (rdstate !== 4'b0100) begin bad++; $display("FAIL midrd_rdstate got=%b want=0100", rdstate); end
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (3) @(negedge clk);
      total++; if (level !== 10'd0) begin bad++; $display("FAIL midrd_no_pend got=%0d want=0", level); end
      total++; if (rdstb !== 1'b1) begin bad++; $display("FAIL midrd_idle got=%b want=1", rdstb); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_start_end();
      test_back_to_back();
      test_full();
      test_afull();
      test_empty_and_hold();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
